// File: rtl/xgpio_ctrl.sv
// xgpio_ctrl: register-mapped GPIO block with synchronised, debounced inputs,
// edge-event capture with a registered interrupt, and optionally blinking outputs.
module xgpio_ctrl #(
    parameter int DATA_W    = 32,
    parameter int N_IN      = 8,
    parameter int N_OUT     = 8,
    parameter int CNT_W     = 16,
    parameter int DEB_RST   = 1000,
    parameter int BLINK_RST = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [2:0]        addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic [N_IN-1:0]   in_pins,
    output logic [N_OUT-1:0]  out_pins,
    output logic              irq
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N_IN-1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_IN-1:0]            stable_q, stable_d, prev_q, prev_d;
    logic [N_IN-1:0]            event_q, event_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_OUT-1:0]           out_q, out_d, blink_en_q, blink_en_d, out_pins_q, out_pins_d;
    logic [CNT_W-1:0]           deb_lim_q, deb_lim_d, blink_div_q, blink_div_d, presc_q, presc_d;
    logic                       phase_q, phase_d, irq_q, irq_d;
    logic                       wr_s, deb_wr_s, blink_wr_s, unused_s;
    logic [N_IN-1:0]            ev_clr_s, ev_set_s;

    assign wr_s     = sel & we;
    assign unused_s = ^data_in;
    assign irq      = irq_q;
    assign out_pins = out_pins_q;

    // Register writes; EVENT only produces a clear mask that is merged with the set logic.
    always_comb begin
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        out_d       = out_q;
        blink_en_d  = blink_en_q;
        deb_lim_d   = deb_lim_q;
        blink_div_d = blink_div_q;
        deb_wr_s    = 1'b0;
        blink_wr_s  = 1'b0;
        ev_clr_s    = '0;
        case ({wr_s, addr})
            4'b1_001: ev_clr_s   = data_in[N_IN-1:0];
            4'b1_010: rise_en_d  = data_in[N_IN-1:0];
            4'b1_011: fall_en_d  = data_in[N_IN-1:0];
            4'b1_100: out_d      = data_in[N_OUT-1:0];
            4'b1_101: blink_en_d = data_in[N_OUT-1:0];
            4'b1_110: begin
                deb_lim_d = data_in[CNT_W-1:0];
                deb_wr_s  = 1'b1;
            end
            4'b1_111: begin
                blink_div_d = data_in[CNT_W-1:0];
                blink_wr_s  = 1'b1;
            end
            default: ;
        endcase
    end

    // Input path: 2-flop synchroniser, mismatch-count debounce, edge events, irq.
    always_comb begin
        sync1_d  = in_pins;
        sync2_d  = sync1_q;
        prev_d   = stable_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < N_IN; i++) begin
            if (deb_wr_s || (sync2_q[i] == stable_q[i])) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == deb_lim_q) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        // Edges are seen one cycle after the stable bit moves; a set beats a same-cycle clear.
        ev_set_s = (stable_q & ~prev_q & rise_en_q) | (~stable_q & prev_q & fall_en_q);
        event_d  = (event_q & ~ev_clr_s) | ev_set_s;
        irq_d    = |event_q;
    end

    // Blink prescaler/phase and the registered output drive.
    always_comb begin
        if (blink_wr_s) begin
            presc_d = '0;
            phase_d = 1'b0;
        end else if (presc_q == blink_div_q) begin
            presc_d = '0;
            phase_d = ~phase_q;
        end else begin
            presc_d = presc_q + CNT_ONE;
            phase_d = phase_q;
        end
        out_pins_d = out_q & (~blink_en_q | {N_OUT{phase_q}});
    end

    // Combinational read mux; anything other than a selected read returns zero.
    always_comb begin
        data_out = '0;
        case ({sel & ~we, addr})
            4'b1_000: data_out = DATA_W'(stable_q);
            4'b1_001: data_out = DATA_W'(event_q);
            4'b1_010: data_out = DATA_W'(rise_en_q);
            4'b1_011: data_out = DATA_W'(fall_en_q);
            4'b1_100: data_out = DATA_W'(out_q);
            4'b1_101: data_out = DATA_W'(blink_en_q);
            4'b1_110: data_out = DATA_W'(deb_lim_q);
            4'b1_111: data_out = DATA_W'(blink_div_q);
            default:  data_out = '0;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            event_q     <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            out_q       <= '0;
            blink_en_q  <= '0;
            deb_lim_q   <= CNT_W'(DEB_RST);
            blink_div_q <= CNT_W'(BLINK_RST);
            presc_q     <= '0;
            phase_q     <= 1'b0;
            irq_q       <= 1'b0;
            out_pins_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            stable_q    <= stable_d;
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            event_q     <= event_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            out_q       <= out_d;
            blink_en_q  <= blink_en_d;
            deb_lim_q   <= deb_lim_d;
            blink_div_q <= blink_div_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            irq_q       <= irq_d;
            out_pins_q  <= out_pins_d;
        end
    end
endmodule

// File: tb/tb_xgpio_ctrl.sv
// Bench for xgpio_ctrl: register table, directed multi-cycle sequences and a
// randomized input/EVENT run checked against a window-based debounce model.
module tb_xgpio_ctrl;
    localparam int NR = 400;

    logic        clk = 1'b0;
    logic        rst, sel, we, irq;
    logic [2:0]  addr;
    logic [31:0] data_in, data_out, d;
    logic [7:0]  in_pins, out_pins;

    int n_vec = 0;
    int n_err = 0;

    xgpio_ctrl dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out),
        .in_pins(in_pins), .out_pins(out_pins), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] p_h [0:NR];

    function automatic vec_t mk(logic s, logic w, logic [2:0] a, logic [31:0] wd, logic [31:0] e);
        vec_t v;
        v.sel = s; v.we = w; v.addr = a; v.wdata = wd; v.exp = e;
        return v;
    endfunction

    function automatic logic [7:0] p_at(int c);
        return (c < 1) ? 8'h00 : p_h[c];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        v = data_out;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        sel = 1'b1; we = 1'b1; addr = a; data_in = v;
        step();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic do_reset();
        in_pins = 8'h00; sel = 1'b0; we = 1'b0; addr = 3'd0; data_in = 32'h0;
        rst = 1'b0;
        #7;
        rst = 1'b1;
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        seen;
        logic [7:0]  rise, fall, st_cur, st_old, st_new, ev, ev_new, clr, mask;
        logic        irq_exp, is_wr, flip;
        logic [2:0]  ra;
        int          last_chg [8];
        int          lim;

        do_reset();
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_out_pins", 32'(out_pins), 32'h0);

        // ---- register table ----
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd1, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd3, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd4, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd5, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd6, 32'h0, 32'd1000));
        tbl.push_back(mk(1'b1, 1'b0, 3'd7, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b1, 3'd2, 32'hFFFF_FFA5, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd2, 32'h0, 32'hA5));
        tbl.push_back(mk(1'b1, 1'b1, 3'd3, 32'h0000_005A, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd3, 32'h0, 32'h5A));
        tbl.push_back(mk(1'b1, 1'b1, 3'd4, 32'h1234_563C, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd4, 32'h0, 32'h3C));
        tbl.push_back(mk(1'b1, 1'b1, 3'd5, 32'h0000_00C3, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd5, 32'h0, 32'hC3));
        tbl.push_back(mk(1'b1, 1'b1, 3'd6, 32'hABCD_1234, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd6, 32'h0, 32'h1234));
        tbl.push_back(mk(1'b1, 1'b1, 3'd7, 32'h0005_0007, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd7, 32'h0, 32'h0007));
        tbl.push_back(mk(1'b1, 1'b1, 3'd0, 32'h0000_00FF, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 32'h0, 32'h0));
        tbl.push_back(mk(1'b1, 1'b1, 3'd1, 32'h0000_00FF, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd1, 32'h0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b1, 3'd4, 32'h0000_0011, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 3'd4, 32'h0, 32'h3C));
        tbl.push_back(mk(1'b0, 1'b0, 3'd4, 32'h0, 32'h0));
        tbl.push_back(mk(1'b0, 1'b0, 3'd6, 32'h0, 32'h0));
        for (int i = 0; i < tbl.size(); i++) begin
            sel = tbl[i].sel; we = tbl[i].we; addr = tbl[i].addr; data_in = tbl[i].wdata;
            #1;
            check($sformatf("tbl[%0d]", i), data_out, tbl[i].exp);
            step();
        end
        sel = 1'b0; we = 1'b0;

        // ---- rise latency: DEB_LIM=4 gives 7 cycles to IN_STATE, +1 EVENT, +1 irq ----
        do_reset();
        wr(3'd2, 32'h01);
        wr(3'd6, 32'd4);
        in_pins[0] = 1'b1;
        repeat (6) step();
        rd(3'd0, d); check("lat_in_c6", d, 32'h0);
        step();
        rd(3'd0, d); check("lat_in_c7", d, 32'h1);
        rd(3'd1, d); check("lat_ev_c7", d, 32'h0);
        step();
        rd(3'd1, d); check("lat_ev_c8", d, 32'h1);
        check("lat_irq_c8", 32'(irq), 32'h0);
        step();
        check("lat_irq_c9", 32'(irq), 32'h1);

        // ---- glitch rejection: 4-cycle pulse ignored, 5-cycle pulse passes ----
        wr(3'd1, 32'hFF);
        wr(3'd2, 32'h04);
        in_pins[2] = 1'b1;
        repeat (4) step();
        in_pins[2] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            rd(3'd0, d);
            if (d[2]) seen = 1'b1;
        end
        check("glitch4_in_seen", 32'(seen), 32'h0);
        rd(3'd1, d); check("glitch4_event", d, 32'h0);
        in_pins[2] = 1'b1;
        repeat (5) step();
        in_pins[2] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            rd(3'd0, d);
            if (d[2]) seen = 1'b1;
        end
        check("pulse5_in_seen", 32'(seen), 32'h1);
        rd(3'd0, d); check("pulse5_in_final", d, 32'h01);
        rd(3'd1, d); check("pulse5_event", d, 32'h04);

        // ---- W1C and set-beats-clear ----
        do_reset();
        wr(3'd2, 32'h05);
        wr(3'd6, 32'd1);
        in_pins = 8'h05;
        repeat (10) step();
        rd(3'd1, d); check("w1c_ev_init", d, 32'h05);
        check("w1c_irq_init", 32'(irq), 32'h1);
        wr(3'd1, 32'h01);
        rd(3'd1, d); check("w1c_ev_after", d, 32'h04);
        step();
        check("w1c_irq_hold", 32'(irq), 32'h1);
        wr(3'd3, 32'h04);
        in_pins[2] = 1'b0;
        repeat (4) step();
        wr(3'd1, 32'h04);
        rd(3'd1, d); check("set_wins", d, 32'h04);
        wr(3'd1, 32'h04);
        rd(3'd1, d); check("w1c_ev_clear", d, 32'h0);
        step();
        check("w1c_irq_low", 32'(irq), 32'h0);

        // ---- blink: BLINK_DIV=2 toggles every 3 cycles, starting low ----
        do_reset();
        wr(3'd4, 32'hFF);
        wr(3'd5, 32'h0F);
        wr(3'd7, 32'd2);
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("blink_k%0d", k), 32'(out_pins),
                  (((k - 1) / 3) % 2 == 1) ? 32'hFF : 32'hF0);
        end

        // ---- reset during blink and pending debounce ----
        wr(3'd6, 32'd4);
        wr(3'd2, 32'hFF);
        wr(3'd3, 32'hFF);
        in_pins[1] = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check("mrst_out_pins", 32'(out_pins), 32'h0);
        check("mrst_irq", 32'(irq), 32'h0);
        rd(3'd6, d); check("mrst_deb_lim", d, 32'd1000);
        rd(3'd1, d); check("mrst_event", d, 32'h0);
        in_pins = 8'h00;
        sel = 1'b0;
        #2;
        rst = 1'b1;
        wr(3'd4, 32'h81);
        check("mrst_out_pins_wr", 32'(out_pins), 32'h0);
        rd(3'd4, d); check("mrst_first_wr", d, 32'h81);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step();
            rd(3'd1, d);
            if (d != 32'h0) seen = 1'b1;
        end
        check("mrst_no_event", 32'(seen), 32'h0);
        check("mrst_out_pins_after", 32'(out_pins), 32'h81);

        // ---- randomized inputs and EVENT clears against a window model ----
        do_reset();
        rise = 8'($urandom);
        fall = 8'($urandom);
        lim  = 3;
        wr(3'd2, 32'(rise));
        wr(3'd3, 32'(fall));
        wr(3'd6, 32'(lim));
        st_cur = 8'h00; st_old = 8'h00; ev = 8'h00;
        for (int i = 0; i < 8; i++) last_chg[i] = 0;
        p_h[0] = 8'h00;
        for (int c = 1; c <= NR; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                mask = 8'h01 << $urandom_range(0, 7);
                in_pins = in_pins ^ mask;
            end
            p_h[c] = in_pins;
            is_wr = ($urandom_range(0, 5) == 0);
            clr = 8'h00;
            ra = 3'($urandom_range(0, 1));
            if (is_wr) begin
                clr = 8'($urandom);
                sel = 1'b1; we = 1'b1; addr = 3'd1; data_in = 32'(clr);
            end else begin
                sel = 1'b1; we = 1'b0; addr = ra; data_in = 32'h0;
            end
            step();
            irq_exp = |ev;
            ev_new = (ev & ~clr) | (st_cur & ~st_old & rise) | (~st_cur & st_old & fall);
            st_new = st_cur;
            for (int i = 0; i < 8; i++) begin
                // flips once the last lim+1 synchronised samples, all after the previous flip, disagree
                flip = (c - lim > last_chg[i]);
                for (int k = 0; k <= lim; k++) begin
                    mask = p_at(c - 2 - k);
                    if (mask[i] == st_cur[i]) flip = 1'b0;
                end
                if (flip) begin
                    st_new[i] = ~st_cur[i];
                    last_chg[i] = c;
                end
            end
            st_old = st_cur;
            st_cur = st_new;
            ev = ev_new;
            check($sformatf("rnd_irq_c%0d", c), 32'(irq), 32'(irq_exp));
            if (is_wr) check($sformatf("rnd_wr_rd_c%0d", c), data_out, 32'h0);
            else check($sformatf("rnd_rd%0d_c%0d", ra, c), data_out,
                       (ra == 3'd0) ? 32'(st_cur) : 32'(ev));
        end
        sel = 1'b0; we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
